// File: rtl/ram_io_pkg.sv
// Purpose : shared bit indices and FSM state type for the RAM_IO memory-side bridge.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package ram_io_pkg;

  // FAB2RAM_C bit positions (bit 2 is reserved and ignored)
  localparam int C_WE  = 0;
  localparam int C_RE  = 1;
  localparam int C_CLR = 3;

  // Config_accessC bit positions
  localparam int CFG_OUTREG = 0;
  localparam int CFG_WFIRST = 1;
  localparam int CFG_HIWP   = 2;
  localparam int CFG_EN     = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/ram_io_sram.sv
// Purpose : behavioural single-port synchronous array, read-first, bit-masked write.
// Latency : rdata is the pre-write contents of addr, one clock after addr is presented.
// Backpressure: none; accepts an access every cycle.
// Ports: clk; we/wmask/addr/wdata write side; rdata registered read data.
// Contents are deliberately not reset so a hard macro can replace this module.
module ram_io_sram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [DATA_W-1:0] wmask,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= (mem[addr] & ~wmask) | (wdata & wmask);
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_io_bridge.sv
// Purpose : registers the fabric RAM_IO buses, drives a 1RW SRAM, returns read data, runs a memory-clear sequencer.
// Latency : write lands one edge after sampling; read data two edges after sampling (three with OUT_REG).
// Backpressure: none; fabric ops arriving while busy (clear running) or disabled are dropped, not queued.
// Ports: UserCLK/resetn; FAB2RAM_D/A/C fabric request; Config_accessC mode bits;
//        RAM2FAB_D read data (holds between reads); busy high while the clear owns the array.
module ram_io_bridge
  import ram_io_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int CTRL_W = 4
) (
  input  logic              UserCLK,
  input  logic              resetn,
  input  logic [DATA_W-1:0] FAB2RAM_D,
  input  logic [ADDR_W-1:0] FAB2RAM_A,
  input  logic [CTRL_W-1:0] FAB2RAM_C,
  input  logic [3:0]        Config_accessC,
  output logic [DATA_W-1:0] RAM2FAB_D,
  output logic              busy
);

  // Input stage
  logic [DATA_W-1:0] d_q;
  logic [ADDR_W-1:0] a_q;
  logic              we_q, re_q, clr_q, clr_prev;
  logic [3:0]        cfg_q;

  // FSM / clear counter
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt;

  // Read pipeline
  logic              s1_vld, s1_outreg, s1_bypass, s1_hiwp;
  logic [DATA_W-1:0] s1_wdat;
  logic              s2_vld;
  logic [DATA_W-1:0] s2_dat;

  // SRAM side
  logic              sram_we;
  logic [DATA_W-1:0] sram_wmask, sram_wdata, sram_rdata;
  logic [ADDR_W-1:0] sram_addr;

  logic              fab_we, fab_re, clr_rise;
  logic [DATA_W-1:0] rd_res;

  logic unused_c2;
  assign unused_c2 = FAB2RAM_C[2];

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      d_q      <= '0;
      a_q      <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      clr_q    <= 1'b0;
      clr_prev <= 1'b0;
      cfg_q    <= '0;
    end else begin
      d_q      <= FAB2RAM_D;
      a_q      <= FAB2RAM_A;
      we_q     <= FAB2RAM_C[C_WE];
      re_q     <= FAB2RAM_C[C_RE];
      clr_q    <= FAB2RAM_C[C_CLR];
      clr_prev <= clr_q;
      cfg_q    <= Config_accessC;
    end
  end

  // Fabric ops only reach the array when enabled and the sequencer is idle.
  assign fab_we   = cfg_q[CFG_EN] && (state == IDLE) && we_q;
  assign fab_re   = cfg_q[CFG_EN] && (state == IDLE) && re_q;
  // clr_prev keeps tracking while busy, so a level held through the clear cannot retrigger.
  assign clr_rise = clr_q && !clr_prev;

  // FSM: state register
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;  // wraps to 0 on the final location
      end
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (clr_rise && cfg_q[CFG_EN]) state_nxt = CLEAR;
      CLEAR:   if (cnt == {ADDR_W{1'b1}})     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs / array port mux
  always_comb begin
    busy       = (state == CLEAR);
    sram_we    = 1'b0;
    sram_addr  = a_q;
    sram_wdata = d_q;
    sram_wmask = '1;
    if (state == CLEAR) begin
      sram_we    = 1'b1;
      sram_addr  = cnt;
      sram_wdata = '0;
    end else begin
      sram_we = fab_we;
      if (cfg_q[CFG_HIWP]) begin
        sram_wmask = {{(DATA_W-8){1'b0}}, 8'hFF};
      end
    end
  end

  ram_io_sram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sram (
    .clk   (UserCLK),
    .we    (sram_we),
    .wmask (sram_wmask),
    .addr  (sram_addr),
    .wdata (sram_wdata),
    .rdata (sram_rdata)
  );

  // The array is read-first, so a write-first collision is rebuilt from the
  // old word (upper byte when protected) and the write data.
  always_comb begin
    rd_res = sram_rdata;
    if (s1_bypass) begin
      rd_res = s1_hiwp ? {sram_rdata[DATA_W-1:8], s1_wdat[7:0]} : s1_wdat;
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      s1_vld    <= 1'b0;
      s1_outreg <= 1'b0;
      s1_bypass <= 1'b0;
      s1_hiwp   <= 1'b0;
      s1_wdat   <= '0;
      s2_vld    <= 1'b0;
      s2_dat    <= '0;
      RAM2FAB_D <= '0;
    end else begin
      s1_vld    <= fab_re;
      s1_outreg <= cfg_q[CFG_OUTREG];
      s1_bypass <= fab_we && fab_re && cfg_q[CFG_WFIRST];
      s1_hiwp   <= cfg_q[CFG_HIWP];
      s1_wdat   <= d_q;
      s2_vld    <= s1_vld && s1_outreg;
      if (s1_vld && s1_outreg) begin
        s2_dat <= rd_res;
      end
      // Output holds unless a read result arrives; an OUT_REG flip mid-stream may drop one.
      if (s2_vld) begin
        RAM2FAB_D <= s2_dat;
      end else if (s1_vld && !s1_outreg) begin
        RAM2FAB_D <= rd_res;
      end
    end
  end

endmodule

// File: tb/tb_ram_io_bridge.sv
module tb_ram_io_bridge;
  import ram_io_pkg::*;

  logic        UserCLK = 1'b0;
  logic        resetn;
  logic [15:0] FAB2RAM_D;
  logic [7:0]  FAB2RAM_A;
  logic [3:0]  FAB2RAM_C;
  logic [3:0]  cfg;
  logic [15:0] RAM2FAB_D;
  logic        busy;

  always #5 UserCLK = ~UserCLK;

  int cyc = 0;
  always @(posedge UserCLK) cyc <= cyc + 1;

  ram_io_bridge #(.DATA_W(16), .ADDR_W(8), .CTRL_W(4)) dut (
    .UserCLK        (UserCLK),
    .resetn         (resetn),
    .FAB2RAM_D      (FAB2RAM_D),
    .FAB2RAM_A      (FAB2RAM_A),
    .FAB2RAM_C      (FAB2RAM_C),
    .Config_accessC (cfg),
    .RAM2FAB_D      (RAM2FAB_D),
    .busy           (busy)
  );

  typedef struct {
    logic [15:0] val;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mem [256];
  int          n_chk = 0;
  int          n_err = 0;
  bit          hold_chk = 1'b0;
  logic [15:0] last_d = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: a read result must appear exactly on its due cycle; otherwise the output holds.
  always @(negedge UserCLK) begin
    while (sb.size() > 0 && sb[0].due < cyc) begin
      check("read_slot_missed", 32'(sb[0].due), 32'(cyc));
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      check("read_data", RAM2FAB_D, sb[0].val);
      void'(sb.pop_front());
    end else if (hold_chk) begin
      check("output_hold", RAM2FAB_D, last_d);
    end
    last_d = RAM2FAB_D;
  end

  // One fabric request for one cycle; the reference model is a plain array
  // updated in issue order, with reads answered from it at issue time.
  task automatic op(input logic we, input logic re, input logic [7:0] a, input logic [15:0] d);
    logic [15:0] oldv, newv;
    exp_t e;
    FAB2RAM_C = {2'b00, re, we};
    FAB2RAM_A = a;
    FAB2RAM_D = d;
    if (cfg[CFG_EN]) begin
      oldv = mem[a];
      newv = cfg[CFG_HIWP] ? {oldv[15:8], d[7:0]} : d;
      if (re) begin
        e.val = (we && cfg[CFG_WFIRST]) ? newv : oldv;
        e.due = cyc + 1 + (cfg[CFG_OUTREG] ? 3 : 2);
        sb.push_back(e);
      end
      if (we) mem[a] = newv;
    end
    @(negedge UserCLK);
    FAB2RAM_C = '0;
  endtask

  task automatic idle(input int n);
    FAB2RAM_C = '0;
    repeat (n) @(negedge UserCLK);
  endtask

  task automatic set_cfg(input logic [3:0] c);
    cfg = c;
    idle(2);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() > 0 && t < 20) begin
      @(negedge UserCLK);
      t++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, first, bcnt;
    logic [3:0] rc;
    resetn    = 1'b0;
    cfg       = '0;
    FAB2RAM_C = '0;
    FAB2RAM_A = '0;
    FAB2RAM_D = '0;
    repeat (3) @(negedge UserCLK);
    check("reset_dout", RAM2FAB_D, 16'h0);
    check("reset_busy", busy, 1'b0);
    resetn = 1'b1;
    @(negedge UserCLK);
    hold_chk = 1'b1;

    // Basic write/read, both output latencies
    set_cfg(4'b1000);
    op(1, 0, 8'h3C, 16'hBEEF);
    op(0, 1, 8'h3C, 16'h0);
    drain();
    set_cfg(4'b1001);
    op(1, 0, 8'h3C, 16'hCAFE);
    op(0, 1, 8'h3C, 16'h0);
    drain();

    // Same-cycle write+read collision
    set_cfg(4'b1010);
    op(1, 0, 8'h10, 16'h1111);
    op(1, 1, 8'h10, 16'h2222);
    drain();
    op(1, 0, 8'h10, 16'h1111);
    set_cfg(4'b1000);
    op(1, 1, 8'h10, 16'h2222);
    op(0, 1, 8'h10, 16'h0);
    drain();

    // Upper-byte write protect
    op(1, 0, 8'h05, 16'hAAAA);
    set_cfg(4'b1100);
    op(1, 0, 8'h05, 16'h1234);
    op(0, 1, 8'h05, 16'h0);
    drain();

    // Clear sequencer
    set_cfg(4'b1000);
    op(1, 0, 8'h00, 16'hFFFF);
    op(1, 0, 8'h7F, 16'hFFFF);
    op(1, 0, 8'hFF, 16'hFFFF);
    op(0, 1, 8'h00, 16'h0);
    op(0, 1, 8'h7F, 16'h0);
    op(0, 1, 8'hFF, 16'h0);
    drain();
    FAB2RAM_C = 4'b1000;
    n0    = cyc + 1;
    first = -1;
    bcnt  = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge UserCLK);
      if (busy) begin
        bcnt++;
        if (first < 0) first = cyc;
      end
      if (i == 200) begin
        FAB2RAM_C = 4'b1001;  // write during busy, CLEAR still held
        FAB2RAM_A = 8'h7F;
        FAB2RAM_D = 16'h1234;
      end else if (i == 201) begin
        FAB2RAM_C = 4'b1010;  // read during busy must not reach the output
        FAB2RAM_A = 8'h00;
      end else if (i == 202) begin
        FAB2RAM_C = 4'b1000;
      end else if (i == 280) begin
        FAB2RAM_C = 4'b0000;
      end
    end
    check("clear_busy_cycles", 32'(bcnt), 32'd256);
    check("clear_busy_start", 32'(first), 32'(n0 + 1));
    check("clear_dout_held", RAM2FAB_D, 16'hFFFF);
    for (int a = 0; a < 256; a++) mem[a] = 16'h0;
    op(0, 1, 8'h00, 16'h0);
    op(0, 1, 8'h7F, 16'h0);
    op(0, 1, 8'hFF, 16'h0);
    drain();

    // Randomized traffic on a small address window
    for (int blk = 0; blk < 4; blk++) begin
      rc = 4'($urandom_range(0, 7));
      rc[CFG_EN] = 1'b1;
      set_cfg(rc);
      for (int k = 0; k < 40; k++) begin
        op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 15)), 16'($urandom));
      end
      drain();
    end

    // ENABLE=0 blocks writes, reads and clear start
    set_cfg(4'b1000);
    op(1, 0, 8'h01, 16'h0101);
    set_cfg(4'b0000);
    op(1, 0, 8'h01, 16'h5555);
    op(0, 1, 8'h01, 16'h0);
    FAB2RAM_C = 4'b1000;
    @(negedge UserCLK);
    FAB2RAM_C = 4'b0000;
    bcnt = 0;
    repeat (8) begin
      @(negedge UserCLK);
      if (busy) bcnt++;
    end
    check("disabled_no_clear", 32'(bcnt), 32'd0);
    set_cfg(4'b1000);
    op(0, 1, 8'h01, 16'h0);
    drain();

    // Reset in the middle of a clear
    op(1, 0, 8'h20, 16'hA5A5);
    op(0, 1, 8'h20, 16'h0);
    drain();
    FAB2RAM_C = 4'b1000;
    @(negedge UserCLK);
    idle(20);
    check("midclear_busy", busy, 1'b1);
    hold_chk = 1'b0;
    #2 resetn = 1'b0;
    #1;
    check("async_reset_dout", RAM2FAB_D, 16'h0);
    check("async_reset_busy", busy, 1'b0);
    @(negedge UserCLK);
    resetn = 1'b1;
    bcnt = 0;
    repeat (5) begin
      @(negedge UserCLK);
      if (busy) bcnt++;
    end
    check("post_reset_idle", 32'(bcnt), 32'd0);
    hold_chk = 1'b1;
    op(1, 0, 8'h30, 16'h7777);
    op(0, 1, 8'h30, 16'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
